// File: rtl/run_det_pkg.sv
// Shared constants for the run-length detector.
package run_det_pkg;

    localparam logic [1:0] MODE_BOTH  = 2'b00;
    localparam logic [1:0] MODE_ONES  = 2'b01;
    localparam logic [1:0] MODE_ZEROS = 2'b10;
    localparam logic [1:0] MODE_OFF   = 2'b11;

    localparam int unsigned CW_DEFAULT  = 4;
    localparam int unsigned HCW_DEFAULT = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a sticky flag for increments lost at full scale.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat_hit
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] cnt_d;
    logic         sat_d;

    // Next count: clear wins over increment; increment at full scale only sets the flag.
    always_comb begin
        cnt_d = cnt;
        sat_d = sat_hit;
        if (clr) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (inc) begin
            if (cnt == CNT_MAX) begin
                sat_d = 1'b1;
            end else begin
                cnt_d = cnt + W'(1);
            end
        end
    end

    // Counter and sticky flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            sat_hit <= 1'b0;
        end else begin
            cnt     <= cnt_d;
            sat_hit <= sat_d;
        end
    end

endmodule

// File: rtl/run_length_detector.sv
// Flags when the serial input has held one value for a programmable number of samples.
module run_length_detector
    import run_det_pkg::*;
#(
    parameter int unsigned CW  = CW_DEFAULT,
    parameter int unsigned HCW = HCW_DEFAULT
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           w,
    input  logic           en,
    input  logic [CW-1:0]  run_len,
    input  logic [1:0]     mode,
    input  logic           overlap,
    input  logic           clear_count,
    output logic           z,
    output logic           z_val,
    output logic [HCW-1:0] hit_count,
    output logic           hit_ovf,
    output logic [CW:0]    LEDR
);

    localparam logic [CW-1:0] RUN_MAX = '1;

    logic [CW-1:0] run_cnt;
    logic [CW-1:0] run_cnt_d;
    logic [CW-1:0] cnt_new;
    logic          last_bit;
    logic          last_bit_d;
    logic          z_d;
    logic          z_val_d;
    logic          same;
    logic          qualify;
    logic          reached;
    logic          hit;

    // Run tracking and detection. A new hit needs a fresh run, a previously short count,
    // or z low beforehand (covers run_len/mode changes that make an ongoing run qualify).
    always_comb begin
        run_cnt_d  = run_cnt;
        last_bit_d = last_bit;
        z_d        = z;
        z_val_d    = z_val;
        hit        = 1'b0;
        same       = (run_cnt != '0) && (w == last_bit);
        cnt_new    = same ? ((run_cnt == RUN_MAX) ? run_cnt : run_cnt + CW'(1)) : CW'(1);
        qualify    = (run_len != '0) &&
                     ((mode == MODE_BOTH) ||
                      ((mode == MODE_ONES) && w) ||
                      ((mode == MODE_ZEROS) && !w));
        reached    = (cnt_new >= run_len);
        if (en) begin
            hit        = qualify && reached && (!same || !z || (run_cnt < run_len));
            last_bit_d = w;
            run_cnt_d  = (hit && !overlap) ? '0 : cnt_new;
            z_d        = overlap ? (qualify && reached) : hit;
            if (z_d) begin
                z_val_d = w;
            end
        end
    end

    // Run state and detect flag registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            run_cnt  <= '0;
            last_bit <= 1'b0;
            z        <= 1'b0;
            z_val    <= 1'b0;
        end else begin
            run_cnt  <= run_cnt_d;
            last_bit <= last_bit_d;
            z        <= z_d;
            z_val    <= z_val_d;
        end
    end

    assign LEDR = {last_bit, run_cnt};

    sat_counter #(
        .W (HCW)
    ) u_hits (
        .clk     (Clk),
        .rst_n   (Reset),
        .clr     (clear_count),
        .inc     (hit),
        .cnt     (hit_count),
        .sat_hit (hit_ovf)
    );

endmodule

// File: doc/run_length_detector.md
Name: run_length_detector

Overview:
- Parametrised run-length detector: flags when the serial input w has held the same value for a runtime-programmable number of consecutive samples.
- Generalises the fixed four-ones/four-zeros detector. Adds:
  - programmable run length
  - polarity mode select
  - overlap/non-overlap selection
  - sample enable
  - saturating hit counter with sticky overflow
  - LED state display.
- Sits between the debounced switch input and the LED/HEX display logic on the lab board top level.

Parameters:
- CW, 4, width of run counter and run_len; maximum trackable run = 2^CW-1.
- HCW, 8, width of hit_count.

Ports:
- Clk  input  1  system clock, rising-edge.
- Reset  input  1  asynchronous, active-low reset.
- w  input  1  serial data bit.
- en  input  1  sample enable; w is sampled only on edges where en=1.
- run_len  input  CW  required run length; 0 disables detection.
- mode  input  2  00 = ones or zeros, 01 = ones only, 10 = zeros only, 11 = detection off.
- overlap  input  1  1 = z stays high while the run continues; 0 = run counter restarts after each hit.
- clear_count  input  1  synchronous clear of hit_count and hit_ovf.
- z  output  1  registered detect flag.
- z_val  output  1  bit value of the run that caused z.
- hit_count  output  HCW  number of detection events.
- hit_ovf  output  1  sticky flag: hit_count saturated.
- LEDR  output  CW+1  state display {last_bit, run_cnt}.

Behaviour:
- **Reset** (Reset=0, asynchronous): run_cnt=0, last_bit=0, z=0, z_val=0, hit_count=0, hit_ovf=0, LEDR=0. A reset mid-run discards the run; the first sample after release starts run_cnt=1.
- **Run counter**, on a rising Clk edge with en=1:
  - if run_cnt != 0 and w == last_bit: run_cnt saturating-increments (holds at 2^CW-1);
  - otherwise: run_cnt=1 and last_bit=w.
- **Non-overlap restart**: when overlap=0 and a hit occurs, run_cnt is loaded with 0 instead. The next sample starts a fresh run (count 1), so a second hit needs run_len further equal samples.
- **qualify** = (run_len != 0) and mode != 11 and (mode == 00, or mode == 01 with w == 1, or mode == 10 with w == 0).
- **Hit**: on an en edge, a hit occurs when qualify=1 and the new run count >= run_len, while the previous count was < run_len or the bit changed.
  - Overlap mode: exactly one hit per run, even though z stays high.
  - Non-overlap mode: one hit every run_len equal samples.
- **z** (registered, updated only on en=1 edges):
  - overlap=1: z = qualify and new run count >= run_len. It stays high while the run continues.
  - overlap=0: z = hit, a one-sample pulse.
  - z_val loads w whenever z is set. Both z and z_val hold when en=0.
- **Latency**: z rises on the same edge that samples the run_len-th equal bit, and is visible the following cycle.
- **run_len=1**: every qualifying sample is a hit in non-overlap mode. In overlap mode there is one hit per run.
- **Mid-run changes to run_len or mode** take effect at the next en edge; the comparison uses the current run_cnt. Lowering run_len below run_cnt in overlap mode raises z and counts one hit at the next matching sample.
- **Hit counter**:
  - hit increments hit_count, saturating at 2^HCW-1.
  - A hit while already saturated sets hit_ovf, which stays set until cleared.
  - clear_count=1 zeroes hit_count and hit_ovf; clear has priority over a simultaneous hit, and that hit is not counted.
  - clear_count does not affect run_cnt or z.
- **LEDR** = {last_bit, run_cnt}, registered.

Decomposition:
- Package run_det_pkg holds:
  - mode encodings MODE_BOTH=2'b00, MODE_ONES=2'b01, MODE_ZEROS=2'b10, MODE_OFF=2'b11;
  - default CW/HCW constants.
- One sub-module, sat_counter (parameter W; inputs clr, inc; outputs cnt, sat_hit), is instantiated for hit_count and hit_ovf. The run counter remains inline because of its load-1/load-0 behaviour.

Test Plan:
- **Predecessor sequence**: run_len=4, mode=00, overlap=1, en=1, w=0,1,1,0,1,1,1,1,0,0,0,0 -> z=1 after sample 8 (z_val=1) and after sample 12 (z_val=0); z=0 after sample 9; hit_count=2.
- **Overlap vs non-overlap**: run_len=3, w = seven 1s.
  - overlap=1 -> z high from sample 3 through 7, hit_count=1.
  - overlap=0 -> z pulses after samples 3 and 6 only, hit_count=2.
- **Mode filter**: run_len=2, mode=10, w=1,1,1,0,0 -> z=0 through sample 3, z=1 after sample 5 with z_val=0; mode=11 -> z never set.
- **Enable and reset**:
  - run_len=4, w=1 with en toggling 1,0,1,0,1,0,1 -> z=1 only after the fourth en=1 edge.
  - Assert Reset low mid-run asynchronously -> all outputs 0 immediately, and the run restarts at count 1.
- **Counter saturation/clear**: HCW=2, run_len=1, overlap=0, w=1 for 4 samples -> hit_count=3, hit_ovf=1; then clear_count together with a hit -> hit_count=0, hit_ovf=0.
- **Edge values**: run_len=0 -> no z for any input; run_len=15 with 20 ones -> z after sample 15; LEDR=5'b11111 from sample 15 onward (run_cnt saturated).
